// File: rtl/dmem_bridge.sv
// Data-memory bridge between the M stage and a split address/data handshake bus.
// It issues exactly one bus transaction per M-stage access and keeps the pipeline stalled until the data returns.
module dmem_bridge (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_en,
  input  logic [3:0]  mem_wen,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic        pipe_stall,
  output logic [31:0] mem_rdata,
  output logic        d_stall,
  output logic        data_req,
  output logic        data_wr,
  output logic [1:0]  data_size,
  output logic [31:0] data_addr,
  output logic [31:0] data_wdata,
  input  logic        data_addr_ok,
  input  logic        data_data_ok,
  input  logic [31:0] data_rdata
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
    S_DATA = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic        r_wr;
  logic [1:0]  r_size;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_rdata;

  logic [3:0]  w_dec;
  logic        w_wr;
  logic [31:0] w_addr;
  logic        w_unused;

  // Byte enables -> {size, byte offset}; loads and irregular masks become aligned words.
  function automatic logic [3:0] f_decode(input logic [3:0] wen);
    logic [3:0] res;
    case (wen)
      4'b1111: res = {2'd2, 2'd0};
      4'b0011: res = {2'd1, 2'd0};
      4'b1100: res = {2'd1, 2'd2};
      4'b0001: res = {2'd0, 2'd0};
      4'b0010: res = {2'd0, 2'd1};
      4'b0100: res = {2'd0, 2'd2};
      4'b1000: res = {2'd0, 2'd3};
      default: res = {2'd2, 2'd0};
    endcase
    return res;
  endfunction

  assign w_dec    = f_decode(mem_wen);
  assign w_wr     = (mem_wen != 4'b0000);
  assign w_addr   = {mem_addr[31:2], w_dec[1:0]};
  assign w_unused = ^mem_addr[1:0];

  // State, request capture and load-data holding register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_wr    <= 1'b0;
      r_size  <= 2'd0;
      r_addr  <= 32'd0;
      r_wdata <= 32'd0;
      r_rdata <= 32'd0;
    end else begin
      r_state <= w_next;
      if (r_state == S_IDLE && mem_en) begin
        r_wr    <= w_wr;
        r_size  <= w_dec[3:2];
        r_addr  <= w_addr;
        r_wdata <= mem_wdata;
      end else begin
        r_wr    <= r_wr;
      end
      if (r_state == S_DATA && data_data_ok) begin
        r_rdata <= data_rdata;
      end else begin
        r_rdata <= r_rdata;
      end
    end
  end

  // Next state and bus/pipeline outputs; IDLE forwards the live request so issue costs no cycle.
  always_comb begin
    w_next     = r_state;
    data_req   = 1'b0;
    data_wr    = r_wr;
    data_size  = r_size;
    data_addr  = r_addr;
    data_wdata = r_wdata;
    d_stall    = 1'b0;
    mem_rdata  = r_rdata;
    case (r_state)
      S_IDLE: begin
        data_req   = mem_en;
        data_wr    = w_wr;
        data_size  = w_dec[3:2];
        data_addr  = w_addr;
        data_wdata = mem_wdata;
        d_stall    = mem_en;
        if (mem_en) begin
          w_next = data_addr_ok ? S_DATA : S_ADDR;
        end else begin
          w_next = S_IDLE;
        end
      end
      S_ADDR: begin
        data_req = 1'b1;
        d_stall  = 1'b1;
        if (data_addr_ok) begin
          w_next = S_DATA;
        end else begin
          w_next = S_ADDR;
        end
      end
      S_DATA: begin
        d_stall = !data_data_ok;
        if (data_data_ok) begin
          mem_rdata = data_rdata;
          w_next    = pipe_stall ? S_DONE : S_IDLE;
        end else begin
          w_next = S_DATA;
        end
      end
      S_DONE: begin
        // Completed access waits here so a long stall cannot re-issue it.
        if (!pipe_stall) begin
          w_next = S_IDLE;
        end else begin
          w_next = S_DONE;
        end
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_dmem_bridge.sv
// Directed bench for dmem_bridge: expected bus requests go to a scoreboard queue checked by a
// negedge monitor; pipeline-side outputs are checked in-line against hand-computed values.
module tb_dmem_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_en;
  logic [3:0]  mem_wen;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        pipe_stall;
  logic [31:0] mem_rdata;
  logic        d_stall;
  logic        data_req;
  logic        data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;

  int n_vec = 0;
  int n_err = 0;
  logic [66:0] req_q[$];

  always #5 clk = ~clk;

  dmem_bridge dut (
    .clk(clk), .rst(rst), .mem_en(mem_en), .mem_wen(mem_wen), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .pipe_stall(pipe_stall), .mem_rdata(mem_rdata), .d_stall(d_stall),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
    .data_rdata(data_rdata)
  );

  task automatic chk(input string nm, input logic [66:0] act, input logic [66:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic push_req(input logic wr, input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd);
    req_q.push_back({wr, sz, a, wd});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every cycle with a live bus request must match the next expected request.
  always @(negedge clk) begin
    if (!rst && data_req) begin
      if (req_q.size() == 0) begin
        chk("unexpected_req", {data_wr, data_size, data_addr, data_wdata}, 67'd0);
      end else begin
        chk("bus_req", {data_wr, data_size, data_addr, data_wdata}, req_q.pop_front());
      end
    end
  end

  logic [3:0]  tw [6] = '{4'b1111, 4'b0011, 4'b0001, 4'b0010, 4'b1000, 4'b0101};
  logic [1:0]  ts [6] = '{2'd2, 2'd1, 2'd0, 2'd0, 2'd0, 2'd2};
  logic [31:0] ta [6] = '{32'h4000_0000, 32'h4000_0000, 32'h4000_0000, 32'h4000_0001,
                          32'h4000_0003, 32'h4000_0000};

  initial begin
    rst = 1'b1; mem_en = 1'b0; mem_wen = 4'd0; mem_addr = 32'd0; mem_wdata = 32'd0;
    pipe_stall = 1'b0; data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = 32'd0;
    tick(); tick();
    @(negedge clk);
    chk("rst_rdata", {35'd0, mem_rdata}, 67'd0);
    chk("rst_req", {66'd0, data_req}, 67'd0);
    chk("rst_stall", {66'd0, d_stall}, 67'd0);
    mem_en = 1'b1;
    #1;
    chk("rst_req_follows_en", {66'd0, data_req}, 67'd1);
    chk("rst_stall_follows_en", {66'd0, d_stall}, 67'd1);
    tick();
    rst = 1'b0; mem_en = 1'b0;
    tick();

    // Load, address accepted on issue, data three cycles later.
    mem_en = 1'b1; mem_wen = 4'd0; mem_addr = 32'h1000_0006; mem_wdata = 32'h1234_5678;
    data_addr_ok = 1'b1;
    push_req(1'b0, 2'd2, 32'h1000_0004, 32'h1234_5678);
    @(negedge clk); chk("ld_stall_c0", {66'd0, d_stall}, 67'd1);
    tick(); data_addr_ok = 1'b0;
    @(negedge clk); chk("ld_stall_c1", {66'd0, d_stall}, 67'd1);
    tick();
    @(negedge clk); chk("ld_stall_c2", {66'd0, d_stall}, 67'd1);
    tick(); data_data_ok = 1'b1; data_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    chk("ld_stall_done", {66'd0, d_stall}, 67'd0);
    chk("ld_rdata_pass", {35'd0, mem_rdata}, {35'd0, 32'hDEAD_BEEF});
    tick(); data_data_ok = 1'b0; data_rdata = 32'h0BAD_F00D; mem_en = 1'b0;
    @(negedge clk);
    chk("ld_idle_stall", {66'd0, d_stall}, 67'd0);
    chk("ld_rdata_hold", {35'd0, mem_rdata}, {35'd0, 32'hDEAD_BEEF});
    tick();

    // Byte store, address accepted after three wait cycles; mem_* disturbed meanwhile.
    mem_en = 1'b1; mem_wen = 4'b0100; mem_addr = 32'h0000_0010; mem_wdata = 32'h00AB_0000;
    push_req(1'b1, 2'd0, 32'h0000_0012, 32'h00AB_0000);
    @(negedge clk); chk("st_stall_c0", {66'd0, d_stall}, 67'd1);
    for (int i = 1; i <= 3; i++) begin
      tick();
      mem_en = 1'b0; mem_addr = 32'hFFFF_FFF0; mem_wdata = 32'd0; mem_wen = 4'b0001;
      data_addr_ok = (i == 3);
      push_req(1'b1, 2'd0, 32'h0000_0012, 32'h00AB_0000);
      @(negedge clk); chk("st_stall_addr", {66'd0, d_stall}, 67'd1);
    end
    tick(); data_addr_ok = 1'b0;
    @(negedge clk);
    chk("st_stall_data", {66'd0, d_stall}, 67'd1);
    chk("st_req_low", {66'd0, data_req}, 67'd0);
    tick(); data_data_ok = 1'b1; data_rdata = 32'd0;
    @(negedge clk); chk("st_stall_done", {66'd0, d_stall}, 67'd0);
    tick(); data_data_ok = 1'b0;

    // Load completing under a long external stall must not re-issue.
    mem_en = 1'b1; mem_wen = 4'd0; mem_addr = 32'h2000_0000; mem_wdata = 32'h0000_0000;
    data_addr_ok = 1'b1;
    push_req(1'b0, 2'd2, 32'h2000_0000, 32'h0000_0000);
    tick(); data_addr_ok = 1'b0; data_data_ok = 1'b1; data_rdata = 32'hCAFE_F00D; pipe_stall = 1'b1;
    @(negedge clk);
    chk("stl_stall_done", {66'd0, d_stall}, 67'd0);
    chk("stl_rdata_pass", {35'd0, mem_rdata}, {35'd0, 32'hCAFE_F00D});
    for (int i = 0; i < 6; i++) begin
      tick(); data_data_ok = 1'b0; data_rdata = 32'h1111_1111; pipe_stall = (i < 5);
      @(negedge clk);
      chk("stl_done_stall", {66'd0, d_stall}, 67'd0);
      chk("stl_done_rdata", {35'd0, mem_rdata}, {35'd0, 32'hCAFE_F00D});
    end
    tick(); mem_en = 1'b0;
    @(negedge clk);
    chk("stl_idle_req", {66'd0, data_req}, 67'd0);
    chk("stl_idle_rdata", {35'd0, mem_rdata}, {35'd0, 32'hCAFE_F00D});
    tick();

    // Upper-half store then an immediate load with no bubble.
    mem_en = 1'b1; mem_wen = 4'b1100; mem_addr = 32'h3000_0001; mem_wdata = 32'hBEEF_0000;
    data_addr_ok = 1'b1;
    push_req(1'b1, 2'd1, 32'h3000_0002, 32'hBEEF_0000);
    tick(); data_addr_ok = 1'b0; data_data_ok = 1'b1;
    @(negedge clk); chk("b2b_st_done", {66'd0, d_stall}, 67'd0);
    tick(); data_data_ok = 1'b0;
    mem_wen = 4'd0; mem_addr = 32'h3000_0008; mem_wdata = 32'h0; data_addr_ok = 1'b1;
    push_req(1'b0, 2'd2, 32'h3000_0008, 32'h0);
    @(negedge clk);
    chk("b2b_ld_req", {66'd0, data_req}, 67'd1);
    chk("b2b_ld_stall", {66'd0, d_stall}, 67'd1);
    tick(); data_addr_ok = 1'b0; data_data_ok = 1'b1; data_rdata = 32'h55AA_55AA;
    @(negedge clk); chk("b2b_ld_rdata", {35'd0, mem_rdata}, {35'd0, 32'h55AA_55AA});
    tick(); data_data_ok = 1'b0; mem_en = 1'b0;

    // Store size/offset table, including an irregular mask.
    for (int k = 0; k < 6; k++) begin
      mem_en = 1'b1; mem_wen = tw[k]; mem_addr = 32'h4000_0003; mem_wdata = 32'hA5A5_0000 + k;
      data_addr_ok = 1'b1;
      push_req(1'b1, ts[k], ta[k], 32'hA5A5_0000 + k);
      tick(); data_addr_ok = 1'b0; data_data_ok = 1'b1;
      tick(); data_data_ok = 1'b0;
    end
    mem_en = 1'b0;

    // Reset in DATA abandons the access; a late data_ok is ignored.
    mem_en = 1'b1; mem_wen = 4'd0; mem_addr = 32'h5000_0000; mem_wdata = 32'd0; data_addr_ok = 1'b1;
    push_req(1'b0, 2'd2, 32'h5000_0000, 32'd0);
    tick(); data_addr_ok = 1'b0; rst = 1'b1;
    tick(); rst = 1'b0; mem_en = 1'b0; data_data_ok = 1'b1; data_rdata = 32'h7777_7777;
    @(negedge clk);
    chk("rst_mid_stall", {66'd0, d_stall}, 67'd0);
    chk("rst_mid_rdata", {35'd0, mem_rdata}, 67'd0);
    tick(); data_data_ok = 1'b0;
    mem_en = 1'b1; mem_addr = 32'h5000_0010; data_addr_ok = 1'b1;
    push_req(1'b0, 2'd2, 32'h5000_0010, 32'd0);
    @(negedge clk);
    chk("rst_after_stall", {66'd0, d_stall}, 67'd1);
    chk("rst_after_rdata", {35'd0, mem_rdata}, 67'd0);
    tick(); data_addr_ok = 1'b0; data_data_ok = 1'b1; data_rdata = 32'h0000_0001;
    tick(); data_data_ok = 1'b0; mem_en = 1'b0;
    tick();

    chk("req_queue_empty", 67'(req_q.size()), 67'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
